instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Writer side of the 6-bit instruction format: packs symbolic {OpCode, RNum} fields into Ins words.
//  Accepts fields over a valid/ready stream and writes the words sequentially into program memory.
//  Optionally pads the unused tail of memory with NOP. Sits between the host/debug loader and program memory.
//  Keeps a running XOR checksum for load verification.
// PARAMETERS
//  ADDR_W    5  program memory address width; DEPTH = 2**ADDR_W words
//  INS_W     6  instruction width, fixed {OpCode[3:0], RNum[1:0]}; do not override
//  FILL_NOP  1  1: after the last word, write {`OPCODE_NOP, 2'b00} to every remaining address
// PORTS
//  Clk        in   1         single clock, rising edge
//  Rst        in   1         synchronous, active-high reset
//  Start      in   1         begin a load; sampled in IDLE, DONE and ERR, ignored otherwise
//  InValid    in   1         InOpCode/InRNum/InLast valid
//  InReady    out  1         encoder accepts a word this cycle
//  InOpCode   in   4         opcode field -> Ins[5:2]
//  InRNum     in   2         register number -> Ins[1:0]
//  InLast     in   1         final word of the program
//  MemWE      out  1         program memory write strobe (registered)
//  MemAddr    out  ADDR_W    write address (registered)
//  MemData    out  INS_W     write data (registered)
//  Busy       out  1         state is LOAD or FILL
//  Done       out  1         level; load completed without error
//  Err        out  1         level; overflow occurred (program longer than DEPTH)
//  WordCount  out  ADDR_W+1  program words accepted in this load; NOP fill words not counted
//  Checksum   out  INS_W     XOR of all accepted program words; fill words not included
// BEHAVIOUR
//  Reset: state=IDLE; InReady, MemWE, Busy, Done and Err = 0.
//   MemAddr, MemData, WordCount and Checksum = 0. The internal address pointer = 0.
//  States:
//   IDLE -Start-> LOAD; DONE/ERR -Start-> LOAD.
//   LOAD: InReady=1 (combinational from state). Handshake is InValid & InReady.
//   LOAD -hs & InLast-> FILL (FILL_NOP=1 and ptr != DEPTH-1) else DONE.
//   LOAD -hs & !InLast & ptr==DEPTH-1-> ERR.
//   FILL: one NOP write per cycle; after writing DEPTH-1 -> DONE.
//  Entry to LOAD: ptr, WordCount and Checksum = 0; Done and Err cleared in the same edge.
//  Handshake at ptr=p: the next edge sets MemWE=1, MemAddr=p, MemData={InOpCode,InRNum}.
//   The same edge increments ptr and WordCount and does Checksum ^= word. Write latency is 1 cycle.
//  MemWE is a 1-cycle strobe per word; it is 0 in every cycle without a write.
//  Overflow: the word at DEPTH-1 is still written. The next edge enters ERR.
//   No further writes. ptr does not wrap into live data.
//  InLast exactly at DEPTH-1: the word is written, then DONE. This is not an error, and no fill occurs.
//  FILL: InReady=0. Writes addresses ptr..DEPTH-1 back-to-back, one per cycle.
//  Start while Busy: ignored. InValid outside LOAD: ignored, no write.
//  Start and InValid in the same cycle in IDLE/DONE/ERR: only Start takes effect.
//   The word is not consumed because InReady=0.
//  Rst mid-LOAD or mid-FILL: the next edge returns all outputs to reset values.
//   MemWE=0 from that edge on. Partially written memory is left as is.
//  WordCount saturates by construction at DEPTH, because ERR stops acceptance.
// STRUCTURE
//  Shared package uproc_isa_pkg: OPCODE_W=4, RNUM_W=2, INS_W=6, opcode constants.
//   It includes OPCODE_NOP and the R0..R3 encodings, and replaces the loose `defines.
//  FSM enum {IDLE, LOAD, FILL, DONE, ERR} is local to this module.
//  No sub-module: the FSM, pointer, packer and checksum are one always_ff plus a small comb block.
// TESTING
//  1. Rst, Start, then 3 words (0x0,1), (0x3,2), (0x2,3, Last) with FILL_NOP=0.
//     -> writes addr0=0x01, addr1=0x0E, addr2=0x0B on consecutive cycles after each handshake.
//     -> Done=1, WordCount=3, Checksum=0x04.
//  2. FILL_NOP=1, ADDR_W=3: 2 words, then Last.
//     -> addresses 2..7 get {OPCODE_NOP,00} in 6 back-to-back strobes.
//     -> Busy stays high until then; WordCount=2.
//  3. ADDR_W=2: 5 words with no Last.
//     -> addresses 0..3 written, 5th word is never accepted (InReady=0), Err=1, WordCount=4.
//  4. ADDR_W=2: 4 words with Last on the 4th -> Done=1, Err=0, no fill writes.
//  5. InValid toggling 1/0 every cycle during LOAD -> exactly one write per handshake, no writes in the gaps.
//     Start pulsed mid-LOAD -> ignored.
//  6. Rst asserted two cycles into FILL -> the next cycle has MemWE=0, state IDLE, all outputs 0.
//     A later Start reloads cleanly.

Source files
------------

// File: rtl/uproc_isa_pkg.sv
// Shared ISA definitions for the 6-bit instruction format {OpCode, RNum}.
// Used by the loader-side encoder and anything else that builds Ins words.
package uproc_isa_pkg;

    localparam int OPCODE_W = 4;
    localparam int RNUM_W   = 2;
    localparam int INS_W    = OPCODE_W + RNUM_W;

    localparam logic [OPCODE_W-1:0] OPCODE_NOP = 4'hF;

    localparam logic [RNUM_W-1:0] R0 = 2'd0;
    localparam logic [RNUM_W-1:0] R1 = 2'd1;
    localparam logic [RNUM_W-1:0] R2 = 2'd2;
    localparam logic [RNUM_W-1:0] R3 = 2'd3;

    function automatic logic [INS_W-1:0] pack_ins(
        input logic [OPCODE_W-1:0] op,
        input logic [RNUM_W-1:0]   rn
    );
        return {op, rn};
    endfunction

endpackage

// File: rtl/instruction_encoder.sv
// Packs {OpCode, RNum} fields from a valid/ready stream into Ins words and
// writes them sequentially into program memory, optionally NOP-filling the tail.
module instruction_encoder #(
    parameter int ADDR_W   = 5,
    parameter int INS_W    = 6,
    parameter bit FILL_NOP = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              InValid,
    output logic              InReady,
    input  logic [3:0]        InOpCode,
    input  logic [1:0]        InRNum,
    input  logic              InLast,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [INS_W-1:0]  MemData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   WordCount,
    output logic [INS_W-1:0]  Checksum
);
    import uproc_isa_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'((2 ** ADDR_W) - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [INS_W-1:0]  NOP_INS = INS_W'(pack_ins(OPCODE_NOP, R0));

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INS_W-1:0]    r_data;
    logic [ADDR_W:0]     r_cnt;
    logic [INS_W-1:0]    r_sum;
    logic                w_hs;
    logic                w_at_end;
    logic                w_start;
    logic [INS_W-1:0]    w_word;

    assign w_word   = INS_W'(pack_ins(InOpCode, InRNum));
    assign w_at_end = (r_ptr == LAST_A);
    assign w_hs     = InValid && (r_state == S_LOAD);
    assign w_start  = Start && ((r_state == S_IDLE) ||
                                (r_state == S_DONE) ||
                                (r_state == S_ERR));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_hs) begin
                    if (InLast) begin
                        w_next = (FILL_NOP && !w_at_end) ? S_FILL : S_DONE;
                    end else if (w_at_end) begin
                        w_next = S_ERR;
                    end
                end
            end
            S_FILL: begin
                if (w_at_end) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pointer holds at the last address instead of wrapping onto live data.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            if (w_start) begin
                r_ptr <= '0;
                r_cnt <= '0;
                r_sum <= '0;
            end
            if (w_hs) begin
                r_we   <= 1'b1;
                r_addr <= r_ptr;
                r_data <= w_word;
                r_cnt  <= r_cnt + CNT_ONE;
                r_sum  <= r_sum ^ w_word;
                if (!w_at_end) r_ptr <= r_ptr + PTR_ONE;
            end
            if (r_state == S_FILL) begin
                r_we   <= 1'b1;
                r_addr <= r_ptr;
                r_data <= NOP_INS;
                if (!w_at_end) r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    assign InReady   = (r_state == S_LOAD);
    assign Busy      = (r_state == S_LOAD) || (r_state == S_FILL);
    assign Done      = (r_state == S_DONE);
    assign Err       = (r_state == S_ERR);
    assign MemWE     = r_we;
    assign MemAddr   = r_addr;
    assign MemData   = r_data;
    assign WordCount = r_cnt;
    assign Checksum  = r_sum;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench: three encoder instances (deep/no-fill, small/fill, tiny/fill)
// share the stream inputs; each has its own Start and write monitor.
module tb_instruction_encoder;
    import uproc_isa_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [2:0] st = 3'b000;
    logic       InValid = 1'b0;
    logic [3:0] InOpCode = 4'h0;
    logic [1:0] InRNum = 2'h0;
    logic       InLast = 1'b0;

    logic a_rdy, a_we, a_busy, a_done, a_err;
    logic [4:0] a_addr;
    logic [5:0] a_data, a_cnt, a_sum;
    logic b_rdy, b_we, b_busy, b_done, b_err;
    logic [2:0] b_addr;
    logic [3:0] b_cnt;
    logic [5:0] b_data, b_sum;
    logic c_rdy, c_we, c_busy, c_done, c_err;
    logic [1:0] c_addr;
    logic [2:0] c_cnt;
    logic [5:0] c_data, c_sum;

    int checks = 0;
    int errors = 0;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    logic [10:0] qc[$];
    logic [10:0] ea, eb, ec;
    int eptr[3];
    int ecnt[3];
    logic [5:0] esum[3];

    always #5 Clk = ~Clk;

    instruction_encoder #(.ADDR_W(5), .INS_W(6), .FILL_NOP(1'b0)) u_a (
        .Clk(Clk), .Rst(Rst), .Start(st[0]), .InValid(InValid),
        .InReady(a_rdy), .InOpCode(InOpCode), .InRNum(InRNum),
        .InLast(InLast), .MemWE(a_we), .MemAddr(a_addr),
        .MemData(a_data), .Busy(a_busy), .Done(a_done), .Err(a_err),
        .WordCount(a_cnt), .Checksum(a_sum)
    );

    instruction_encoder #(.ADDR_W(3), .INS_W(6), .FILL_NOP(1'b1)) u_b (
        .Clk(Clk), .Rst(Rst), .Start(st[1]), .InValid(InValid),
        .InReady(b_rdy), .InOpCode(InOpCode), .InRNum(InRNum),
        .InLast(InLast), .MemWE(b_we), .MemAddr(b_addr),
        .MemData(b_data), .Busy(b_busy), .Done(b_done), .Err(b_err),
        .WordCount(b_cnt), .Checksum(b_sum)
    );

    instruction_encoder #(.ADDR_W(2), .INS_W(6), .FILL_NOP(1'b1)) u_c (
        .Clk(Clk), .Rst(Rst), .Start(st[2]), .InValid(InValid),
        .InReady(c_rdy), .InOpCode(InOpCode), .InRNum(InRNum),
        .InLast(InLast), .MemWE(c_we), .MemAddr(c_addr),
        .MemData(c_data), .Busy(c_busy), .Done(c_done), .Err(c_err),
        .WordCount(c_cnt), .Checksum(c_sum)
    );

    // Write monitors: every strobe must match the oldest expected write.
    always @(negedge Clk) begin
        if (a_we === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL wr_a unexpected addr=%0d data=%h required no write", a_addr, a_data);
            end else begin
                ea = qa.pop_front();
                if ({a_addr, a_data} !== ea) begin
                    errors++;
                    $display("FAIL wr_a got addr=%0d data=%h required addr=%0d data=%h",
                             a_addr, a_data, ea[10:6], ea[5:0]);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (b_we === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL wr_b unexpected addr=%0d data=%h required no write", b_addr, b_data);
            end else begin
                eb = qb.pop_front();
                if ({2'b00, b_addr, b_data} !== eb) begin
                    errors++;
                    $display("FAIL wr_b got addr=%0d data=%h required addr=%0d data=%h",
                             b_addr, b_data, eb[10:6], eb[5:0]);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (c_we === 1'b1) begin
            checks++;
            if (qc.size() == 0) begin
                errors++;
                $display("FAIL wr_c unexpected addr=%0d data=%h required no write", c_addr, c_data);
            end else begin
                ec = qc.pop_front();
                if ({3'b000, c_addr, c_data} !== ec) begin
                    errors++;
                    $display("FAIL wr_c got addr=%0d data=%h required addr=%0d data=%h",
                             c_addr, c_data, ec[10:6], ec[5:0]);
                end
            end
        end
    end

    function automatic int depth(int i);
        case (i)
            0: return 32;
            1: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic bit fills(int i);
        return i != 0;
    endfunction

    function automatic logic f_rdy(int i);
        case (i)
            0: return a_rdy;
            1: return b_rdy;
            default: return c_rdy;
        endcase
    endfunction

    function automatic logic f_busy(int i);
        case (i)
            0: return a_busy;
            1: return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic [2:0] f_flags(int i);
        case (i)
            0: return {a_done, a_err, a_busy};
            1: return {b_done, b_err, b_busy};
            default: return {c_done, c_err, c_busy};
        endcase
    endfunction

    function automatic logic [5:0] f_cnt(int i);
        case (i)
            0: return a_cnt;
            1: return {2'b00, b_cnt};
            default: return {3'b000, c_cnt};
        endcase
    endfunction

    function automatic logic [5:0] f_sum(int i);
        case (i)
            0: return a_sum;
            1: return b_sum;
            default: return c_sum;
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic push(int i, int addr, logic [5:0] w);
        logic [10:0] e;
        e = {5'(addr), w};
        case (i)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic do_start(int i);
        st[i] = 1'b1;
        @(posedge Clk);
        #1;
        st[i] = 1'b0;
        eptr[i] = 0;
        ecnt[i] = 0;
        esum[i] = 6'h00;
    endtask

    // Offers one word; returns whether it was accepted within a short window.
    task automatic send(int i, logic [3:0] op, logic [1:0] rn, logic last,
                        output bit acc);
        bit hs;
        logic [5:0] w;
        w = {op, rn};
        InValid = 1'b1;
        InOpCode = op;
        InRNum = rn;
        InLast = last;
        acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            hs = f_rdy(i);
            if (hs) begin
                push(i, eptr[i], w);
                ecnt[i]++;
                esum[i] ^= w;
                if (last && fills(i)) begin
                    for (int a = eptr[i] + 1; a < depth(i); a++)
                        push(i, a, {OPCODE_NOP, R0});
                end
                eptr[i]++;
            end
            @(posedge Clk);
            #1;
            if (hs) begin
                acc = 1'b1;
                break;
            end
        end
        InValid = 1'b0;
        InLast = 1'b0;
    endtask

    task automatic wait_idle(int i, output int n);
        n = 0;
        while (f_busy(i) && n < 64) begin
            @(posedge Clk);
            #1;
            n++;
        end
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        checks++;
        if ({a_we, a_rdy, a_busy, a_done, a_err, a_addr, a_data, a_cnt, a_sum} !== '0) begin
            errors++;
            $display("FAIL reset_a got we=%b rdy=%b busy=%b done=%b err=%b cnt=%0d sum=%h required all 0",
                     a_we, a_rdy, a_busy, a_done, a_err, a_cnt, a_sum);
        end
        checks++;
        if ({b_we, b_rdy, b_busy, b_done, b_err, b_addr, b_data, b_cnt, b_sum} !== '0) begin
            errors++;
            $display("FAIL reset_b got we=%b rdy=%b busy=%b cnt=%0d sum=%h required all 0",
                     b_we, b_rdy, b_busy, b_cnt, b_sum);
        end
        checks++;
        if ({c_we, c_rdy, c_busy, c_done, c_err, c_addr, c_data, c_cnt, c_sum} !== '0) begin
            errors++;
            $display("FAIL reset_c got we=%b rdy=%b busy=%b cnt=%0d sum=%h required all 0",
                     c_we, c_rdy, c_busy, c_cnt, c_sum);
        end
    endtask

    task automatic test_basic;
        bit acc;
        int n;
        do_start(0);
        checks++;
        if (a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready got %b required 1", a_rdy);
        end
        send(0, 4'h0, 2'd1, 1'b0, acc);
        send(0, 4'h3, 2'd2, 1'b0, acc);
        send(0, 4'h2, 2'd3, 1'b1, acc);
        wait_idle(0, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL basic_busy_tail got %0d cycles required 0", n);
        end
        checks++;
        if (f_flags(0) !== 3'b100) begin
            errors++;
            $display("FAIL basic_flags got done,err,busy=%b required 100", f_flags(0));
        end
        checks++;
        if (a_cnt !== 6'd3 || a_sum !== 6'h04) begin
            errors++;
            $display("FAIL basic_count got cnt=%0d sum=%h required cnt=3 sum=04", a_cnt, a_sum);
        end
        checks++;
        if (qsize(0) !== 0) begin
            errors++;
            $display("FAIL basic_writes got %0d pending required 0", qsize(0));
        end
    endtask

    task automatic test_fill;
        bit acc;
        int n;
        do_start(1);
        send(1, 4'h1, 2'd0, 1'b0, acc);
        send(1, 4'h5, 2'd3, 1'b1, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL fill_accept got %b required 1", acc);
        end
        wait_idle(1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL fill_busy got %0d cycles required 6", n);
        end
        checks++;
        if (f_flags(1) !== 3'b100) begin
            errors++;
            $display("FAIL fill_flags got done,err,busy=%b required 100", f_flags(1));
        end
        checks++;
        if (b_cnt !== 4'd2 || b_sum !== esum[1]) begin
            errors++;
            $display("FAIL fill_count got cnt=%0d sum=%h required cnt=2 sum=%h", b_cnt, b_sum, esum[1]);
        end
        checks++;
        if (qsize(1) !== 0) begin
            errors++;
            $display("FAIL fill_writes got %0d pending required 0", qsize(1));
        end
    endtask

    task automatic test_overflow;
        bit acc;
        int n;
        do_start(2);
        for (int k = 0; k < 4; k++) begin
            send(2, 4'(k + 6), 2'(k), 1'b0, acc);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL ovf_accept%0d got %b required 1", k, acc);
            end
        end
        send(2, 4'hA, 2'd2, 1'b0, acc);
        checks++;
        if (acc !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fifth got accepted=%b required 0", acc);
        end
        wait_idle(2, n);
        checks++;
        if (f_flags(2) !== 3'b010) begin
            errors++;
            $display("FAIL ovf_flags got done,err,busy=%b required 010", f_flags(2));
        end
        checks++;
        if (c_cnt !== 3'd4 || c_sum !== esum[2]) begin
            errors++;
            $display("FAIL ovf_count got cnt=%0d sum=%h required cnt=4 sum=%h", c_cnt, c_sum, esum[2]);
        end
        checks++;
        if (qsize(2) !== 0) begin
            errors++;
            $display("FAIL ovf_writes got %0d pending required 0", qsize(2));
        end
    endtask

    task automatic test_exact_fit;
        bit acc;
        int n;
        do_start(2);
        checks++;
        if (f_flags(2) !== 3'b001 || c_cnt !== 3'd0) begin
            errors++;
            $display("FAIL fit_restart got flags=%b cnt=%0d required 001 cnt=0", f_flags(2), c_cnt);
        end
        for (int k = 0; k < 4; k++)
            send(2, 4'(3 * k + 1), 2'(3 - k), k == 3, acc);
        wait_idle(2, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL fit_nofill got %0d busy cycles required 0", n);
        end
        checks++;
        if (f_flags(2) !== 3'b100) begin
            errors++;
            $display("FAIL fit_flags got done,err,busy=%b required 100", f_flags(2));
        end
        checks++;
        if (c_cnt !== 3'd4 || c_sum !== esum[2]) begin
            errors++;
            $display("FAIL fit_count got cnt=%0d sum=%h required cnt=4 sum=%h", c_cnt, c_sum, esum[2]);
        end
        checks++;
        if (qsize(2) !== 0) begin
            errors++;
            $display("FAIL fit_writes got %0d pending required 0", qsize(2));
        end
    endtask

    task automatic test_toggle_valid;
        bit acc;
        int n;
        do_start(0);
        for (int k = 0; k < 5; k++) begin
            send(0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), k == 4, acc);
            if (k < 4) begin
                if (k == 1) st[0] = 1'b1;
                @(posedge Clk);
                #1;
                st[0] = 1'b0;
            end
        end
        wait_idle(0, n);
        checks++;
        if (f_flags(0) !== 3'b100) begin
            errors++;
            $display("FAIL toggle_flags got done,err,busy=%b required 100", f_flags(0));
        end
        checks++;
        if (a_cnt !== 6'd5 || a_sum !== esum[0]) begin
            errors++;
            $display("FAIL toggle_count got cnt=%0d sum=%h required cnt=5 sum=%h", a_cnt, a_sum, esum[0]);
        end
        checks++;
        if (qsize(0) !== 0) begin
            errors++;
            $display("FAIL toggle_writes got %0d pending required 0", qsize(0));
        end
    endtask

    task automatic test_reset_in_fill;
        bit acc;
        int n;
        do_start(1);
        send(1, 4'h7, 2'd1, 1'b1, acc);
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        qb.delete();
        checks++;
        if ({b_we, b_rdy, b_busy, b_done, b_err, b_addr, b_data, b_cnt, b_sum} !== '0) begin
            errors++;
            $display("FAIL rst_fill got we=%b busy=%b done=%b addr=%0d cnt=%0d sum=%h required all 0",
                     b_we, b_busy, b_done, b_addr, b_cnt, b_sum);
        end
        do_start(1);
        send(1, 4'h9, 2'd2, 1'b1, acc);
        wait_idle(1, n);
        checks++;
        if (n !== 7 || f_flags(1) !== 3'b100) begin
            errors++;
            $display("FAIL rst_reload got busy=%0d flags=%b required busy=7 flags=100", n, f_flags(1));
        end
        checks++;
        if (b_cnt !== 4'd1 || b_sum !== 6'h26) begin
            errors++;
            $display("FAIL rst_reload_count got cnt=%0d sum=%h required cnt=1 sum=26", b_cnt, b_sum);
        end
        checks++;
        if (qsize(1) !== 0) begin
            errors++;
            $display("FAIL rst_reload_writes got %0d pending required 0", qsize(1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_overflow();
        test_exact_fit();
        test_toggle_valid();
        test_reset_in_fill();
        repeat (3) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
